key_sw_io_device: RTL and testbench
===================================

Name: key_sw_io_device

Overview:
- Memory-mapped input responder for the Project2 processor's data bus; the processor is the initiator.
- Synchronizes the board KEY and SW pins and debounces the switches.
- Presents KEY and SW state at data and control addresses, each with sticky ready and overrun status bits and an interrupt-enable bit.
- Sits beside the data memory; the top-level muxes `memRdData` into the load path when `selected` is high.

Parameters:
- DBITS, 32, bus data/address width.
- ADDR_KDATA, 32'hF0000010, key data register address.
- ADDR_KCTRL, 32'hF0000110, key control/status register address.
- ADDR_SDATA, 32'hF0000014, switch data register address.
- ADDR_SCTRL, 32'hF0000114, switch control/status register address.
- KEY_BITS, 4, number of keys.
- SW_BITS, 10, number of switches.
- DEBOUNCE_CYCLES, 100000, stable cycles required before a switch change is accepted; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- KEY  in  KEY_BITS  raw board keys, active-low.
- SW  in  SW_BITS  raw board switches.
- memAddr  in  DBITS  bus address.
- memRdEn  in  1  load strobe; read side effects are taken at the clock edge.
- memWrEn  in  1  store strobe.
- memWrData  in  DBITS  store data.
- memRdData  out  DBITS  read data, combinational from `memAddr`.
- selected  out  1  high when `memAddr` matches any of the four addresses.
- irq  out  1  interrupt request, registered-state combinational.

Behaviour:
- Reset: every register clears to 0.
  - This covers the synchronizer flops (stored post-inversion, so 0 = released), KDATA, SDATA, the debounce counter, and all ready, overrun and IE bits.
  - Outputs during and after reset: `irq`=0; `memRdData` follows the address.
- Key path:
  - Two-flop synchronizer on ~KEY.
  - At every edge, KDATA <= ksync2.
  - If ksync2 != KDATA at that edge, a key event fires.
  - Latency: a pin change stable before edge N appears in KDATA and sets ready at edge N+2.
- Switch path:
  - Two-flop synchronizer on SW, then the debounce counter `cnt`.
  - If ssync2 == SDATA: `cnt` <= 0.
  - Else if `cnt` == DEBOUNCE_CYCLES-1: SDATA <= ssync2, `cnt` <= 0, and a switch event fires.
  - Else: `cnt` <= `cnt`+1.
  - A stable change before edge N lands at edge N+1+DEBOUNCE_CYCLES.
  - Any glitch that returns to SDATA earlier resets `cnt`; no event fires.
  - Bounce to a different non-SDATA value does not reset `cnt`.
- Status bits, per channel (key and switch are independent):
  - CTRL bit0 = ready, bit2 = overrun, bit4 = IE; all other bits read 0.
  - Event with ready=1 and no clearing read in the same cycle: overrun <= 1, ready stays 1.
  - Event only: ready <= 1.
  - Clearing read only: a read of the DATA address with `memRdEn` clears ready at the edge.
  - Clearing read and event in the same cycle: ready stays 1, overrun unchanged (the event wins).
  - Reading a CTRL address has no side effect.
- Writes, taken when `memWrEn` and an address matches:
  - To CTRL: IE <= memWrData[4]. If memWrData[2]==0, overrun <= 0; writing 1 leaves it unchanged. Bit0 is ignored.
  - To DATA addresses: ignored.
  - Overrun set and overrun clear in the same cycle: set wins.
- Read data:
  - KDATA and SDATA are zero-extended to DBITS.
  - Unmapped address: `memRdData`=0 and `selected`=0.
  - `memRdEn`/`memWrEn` on an unmapped address: no effect.
- `irq` = (kready & kIE) | (sready & sIE).
- A reset asserted mid-debounce discards the count and any pending change; the same applies to reset mid-synchronization.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset with KEY=4'hF, SW=0: after reset, read ADDR_KDATA -> 0, ADDR_KCTRL -> 0, `irq`=0, `selected`=1; read 32'hF0000018 -> 0, `selected`=0.
- KEY goes 4'hF→4'hE before edge N -> KDATA=1 and KCTRL=32'h1 from edge N+2. Then read ADDR_KDATA with `memRdEn` -> returns 1, KCTRL=0 after the edge.
- Two key changes (4'hE then 4'hC, 5 cycles apart) without reading -> KCTRL=32'h5. Write 0 to ADDR_KCTRL -> KCTRL=32'h1.
- SW 0→10'h3FF held -> SDATA=32'h3FF at edge N+5, sready=1. SW 0→1 for 2 cycles then back to 0 -> SDATA stays 0, no event.
- Write 32'h10 to ADDR_SCTRL, then a switch event -> `irq`=1. Read ADDR_SDATA in the same cycle as a new event -> ready stays 1, overrun 0.
- Key event pending, then reset asserted for 1 cycle -> all CTRL=0, `irq`=0, KDATA=0.

Source files
------------

// File: rtl/key_sw_io_device.sv
// Memory-mapped KEY/SW input responder for the processor data bus.
// Synchronizes keys, synchronizes and debounces switches, and exposes data plus ready/overrun/IE status.
module key_sw_io_device #(
    parameter int                DBITS           = 32,
    parameter logic [DBITS-1:0]  ADDR_KDATA      = 32'hF0000010,
    parameter logic [DBITS-1:0]  ADDR_KCTRL      = 32'hF0000110,
    parameter logic [DBITS-1:0]  ADDR_SDATA      = 32'hF0000014,
    parameter logic [DBITS-1:0]  ADDR_SCTRL      = 32'hF0000114,
    parameter int                KEY_BITS        = 4,
    parameter int                SW_BITS         = 10,
    parameter int                DEBOUNCE_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] KEY,
    input  logic [SW_BITS-1:0]  SW,
    input  logic [DBITS-1:0]    memAddr,
    input  logic                memRdEn,
    input  logic                memWrEn,
    input  logic [DBITS-1:0]    memWrData,
    output logic [DBITS-1:0]    memRdData,
    output logic                selected,
    output logic                irq
);

    // Bus contract: no handshake. memRdData/selected are combinational from
    // memAddr; memRdEn and memWrEn are single-cycle strobes whose side effects
    // (ready clear, CTRL write) are taken at the rising clock edge.

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int BIT_READY   = 0;
    localparam int BIT_OVERRUN = 2;
    localparam int BIT_IE      = 4;

    // Address decode
    logic hit_kdata;
    logic hit_kctrl;
    logic hit_sdata;
    logic hit_sctrl;

    assign hit_kdata = (memAddr == ADDR_KDATA);
    assign hit_kctrl = (memAddr == ADDR_KCTRL);
    assign hit_sdata = (memAddr == ADDR_SDATA);
    assign hit_sctrl = (memAddr == ADDR_SCTRL);
    assign selected  = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;

    // State registers
    logic [KEY_BITS-1:0] ksync1_q, ksync1_d;
    logic [KEY_BITS-1:0] ksync2_q, ksync2_d;
    logic [KEY_BITS-1:0] kdata_q,  kdata_d;
    logic [SW_BITS-1:0]  ssync1_q, ssync1_d;
    logic [SW_BITS-1:0]  ssync2_q, ssync2_d;
    logic [SW_BITS-1:0]  sdata_q,  sdata_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                kready_q, kready_d;
    logic                kovr_q,   kovr_d;
    logic                kie_q,    kie_d;
    logic                sready_q, sready_d;
    logic                sovr_q,   sovr_d;
    logic                sie_q,    sie_d;

    logic key_event;
    logic sw_event;
    logic krd_clear;
    logic srd_clear;
    logic kctrl_wr;
    logic sctrl_wr;

    assign krd_clear = memRdEn && hit_kdata;
    assign srd_clear = memRdEn && hit_sdata;
    assign kctrl_wr  = memWrEn && hit_kctrl;
    assign sctrl_wr  = memWrEn && hit_sctrl;

    // Key path: synchronizer only; keys are stored active-high.
    always_comb begin
        ksync1_d  = ~KEY;
        ksync2_d  = ksync1_q;
        kdata_d   = ksync2_q;
        key_event = (ksync2_q != kdata_q);
    end

    // Switch path: a change is accepted only after it has differed from
    // SDATA for DEBOUNCE_CYCLES consecutive edges. Bounces among non-SDATA
    // values keep counting; only a return to SDATA restarts the count.
    always_comb begin
        ssync1_d = SW;
        ssync2_d = ssync1_q;
        sdata_d  = sdata_q;
        cnt_d    = cnt_q;
        sw_event = 1'b0;
        if (ssync2_q == sdata_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            sdata_d  = ssync2_q;
            cnt_d    = '0;
            sw_event = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Status bits. An event always wins over a clearing read or an overrun
    // clear in the same cycle.
    always_comb begin
        kready_d = kready_q;
        kovr_d   = kovr_q;
        kie_d    = kie_q;
        sready_d = sready_q;
        sovr_d   = sovr_q;
        sie_d    = sie_q;

        if (kctrl_wr) begin
            kie_d = memWrData[BIT_IE];
            if (!memWrData[BIT_OVERRUN]) kovr_d = 1'b0;
        end
        if (key_event) begin
            kready_d = 1'b1;
            if (kready_q && !krd_clear) kovr_d = 1'b1;
        end else if (krd_clear) begin
            kready_d = 1'b0;
        end

        if (sctrl_wr) begin
            sie_d = memWrData[BIT_IE];
            if (!memWrData[BIT_OVERRUN]) sovr_d = 1'b0;
        end
        if (sw_event) begin
            sready_d = 1'b1;
            if (sready_q && !srd_clear) sovr_d = 1'b1;
        end else if (srd_clear) begin
            sready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ksync1_q <= '0;
            ksync2_q <= '0;
            kdata_q  <= '0;
            ssync1_q <= '0;
            ssync2_q <= '0;
            sdata_q  <= '0;
            cnt_q    <= '0;
            kready_q <= 1'b0;
            kovr_q   <= 1'b0;
            kie_q    <= 1'b0;
            sready_q <= 1'b0;
            sovr_q   <= 1'b0;
            sie_q    <= 1'b0;
        end else begin
            ksync1_q <= ksync1_d;
            ksync2_q <= ksync2_d;
            kdata_q  <= kdata_d;
            ssync1_q <= ssync1_d;
            ssync2_q <= ssync2_d;
            sdata_q  <= sdata_d;
            cnt_q    <= cnt_d;
            kready_q <= kready_d;
            kovr_q   <= kovr_d;
            kie_q    <= kie_d;
            sready_q <= sready_d;
            sovr_q   <= sovr_d;
            sie_q    <= sie_d;
        end
    end

    // Read data mux
    logic [DBITS-1:0] kctrl_word;
    logic [DBITS-1:0] sctrl_word;

    always_comb begin
        kctrl_word              = '0;
        kctrl_word[BIT_READY]   = kready_q;
        kctrl_word[BIT_OVERRUN] = kovr_q;
        kctrl_word[BIT_IE]      = kie_q;
        sctrl_word              = '0;
        sctrl_word[BIT_READY]   = sready_q;
        sctrl_word[BIT_OVERRUN] = sovr_q;
        sctrl_word[BIT_IE]      = sie_q;

        memRdData = '0;
        if (hit_kdata)      memRdData = {{(DBITS-KEY_BITS){1'b0}}, kdata_q};
        else if (hit_kctrl) memRdData = kctrl_word;
        else if (hit_sdata) memRdData = {{(DBITS-SW_BITS){1'b0}}, sdata_q};
        else if (hit_sctrl) memRdData = sctrl_word;
    end

    assign irq = (kready_q & kie_q) | (sready_q & sie_q);

    // Only bits 2 and 4 of store data carry meaning.
    logic unused_wr_bits;
    assign unused_wr_bits = ^{memWrData[DBITS-1:5], memWrData[3], memWrData[1:0]};

endmodule

// File: tb/tb_key_sw_io_device.sv
// Directed self-checking bench for key_sw_io_device with a short debounce window.
`timescale 1ns/1ps
module tb_key_sw_io_device;

    localparam logic [31:0] A_KDATA = 32'hF0000010;
    localparam logic [31:0] A_KCTRL = 32'hF0000110;
    localparam logic [31:0] A_SDATA = 32'hF0000014;
    localparam logic [31:0] A_SCTRL = 32'hF0000114;
    localparam logic [31:0] A_NONE  = 32'hF0000018;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [31:0] memAddr;
    logic        memRdEn;
    logic        memWrEn;
    logic [31:0] memWrData;
    logic [31:0] memRdData;
    logic        selected;
    logic        irq;

    int errors = 0;
    int checks = 0;

    key_sw_io_device #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .KEY(KEY), .SW(SW),
        .memAddr(memAddr), .memRdEn(memRdEn), .memWrEn(memWrEn),
        .memWrData(memWrData), .memRdData(memRdData),
        .selected(selected), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_addr(input logic [31:0] a);
        memAddr = a;
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        memAddr = a; memWrData = d; memWrEn = 1'b1;
        step(1);
        memWrEn = 1'b0; memWrData = '0;
    endtask

    task automatic bus_read_clear(input logic [31:0] a);
        memAddr = a; memRdEn = 1'b1;
        step(1);
        memRdEn = 1'b0;
    endtask

    task automatic test_reset;
        KEY = 4'hF; SW = '0; memAddr = A_KDATA; memRdEn = 0; memWrEn = 0; memWrData = '0;
        reset = 1'b1;
        step(2);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_in_reset: got %b want 0", irq); end
        reset = 1'b0;
        step(1);
        set_addr(A_KDATA);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL reset_kdata: got %h want 0", memRdData); end
        checks++; if (selected !== 1'b1) begin errors++; $display("FAIL reset_sel: got %b want 1", selected); end
        set_addr(A_KCTRL);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL reset_kctrl: got %h want 0", memRdData); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        set_addr(A_NONE);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL unmapped_data: got %h want 0", memRdData); end
        checks++; if (selected !== 1'b0) begin errors++; $display("FAIL unmapped_sel: got %b want 0", selected); end
        // Writes to unmapped and DATA addresses must not touch IE.
        bus_write(A_NONE, 32'h10);
        bus_write(A_KDATA, 32'h10);
        set_addr(A_KCTRL);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL ignored_wr_kctrl: got %h want 0", memRdData); end
        set_addr(A_SCTRL);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL ignored_wr_sctrl: got %h want 0", memRdData); end
    endtask

    task automatic test_key_event;
        KEY = 4'hE;
        step(1);
        set_addr(A_KDATA);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL key_lat_n: got %h want 0", memRdData); end
        step(1);
        set_addr(A_KDATA);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL key_lat_n1: got %h want 0", memRdData); end
        step(1);
        set_addr(A_KDATA);
        checks++; if (memRdData !== 32'h1) begin errors++; $display("FAIL key_lat_n2: got %h want 1", memRdData); end
        set_addr(A_KCTRL);
        checks++; if (memRdData !== 32'h1) begin errors++; $display("FAIL key_ready: got %h want 1", memRdData); end
        memAddr = A_KDATA; memRdEn = 1'b1;
        #1;
        checks++; if (memRdData !== 32'h1) begin errors++; $display("FAIL key_read_val: got %h want 1", memRdData); end
        step(1);
        memRdEn = 1'b0;
        set_addr(A_KCTRL);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL key_ready_clr: got %h want 0", memRdData); end
    endtask

    task automatic test_key_overrun;
        KEY = 4'hF;
        step(4);
        bus_read_clear(A_KDATA);
        set_addr(A_KCTRL);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL ovr_pre: got %h want 0", memRdData); end
        KEY = 4'hE;
        step(5);
        KEY = 4'hC;
        step(5);
        set_addr(A_KDATA);
        checks++; if (memRdData !== 32'h3) begin errors++; $display("FAIL ovr_kdata: got %h want 3", memRdData); end
        set_addr(A_KCTRL);
        checks++; if (memRdData !== 32'h5) begin errors++; $display("FAIL ovr_kctrl: got %h want 5", memRdData); end
        bus_write(A_KCTRL, 32'h4);
        set_addr(A_KCTRL);
        checks++; if (memRdData !== 32'h5) begin errors++; $display("FAIL ovr_keep: got %h want 5", memRdData); end
        bus_write(A_KCTRL, 32'h0);
        set_addr(A_KCTRL);
        checks++; if (memRdData !== 32'h1) begin errors++; $display("FAIL ovr_clear: got %h want 1", memRdData); end
        bus_read_clear(A_KDATA);
        set_addr(A_KCTRL);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL ovr_ready_clr: got %h want 0", memRdData); end
    endtask

    task automatic test_switch;
        SW = 10'h3FF;
        step(5);
        set_addr(A_SDATA);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL sw_early: got %h want 0", memRdData); end
        step(1);
        set_addr(A_SDATA);
        checks++; if (memRdData !== 32'h3FF) begin errors++; $display("FAIL sw_land: got %h want 3ff", memRdData); end
        set_addr(A_SCTRL);
        checks++; if (memRdData !== 32'h1) begin errors++; $display("FAIL sw_ready: got %h want 1", memRdData); end
        bus_read_clear(A_SDATA);
        // Short glitch away and back: count restarts, nothing lands.
        SW = 10'h3FE;
        step(2);
        SW = 10'h3FF;
        step(8);
        set_addr(A_SDATA);
        checks++; if (memRdData !== 32'h3FF) begin errors++; $display("FAIL glitch_data: got %h want 3ff", memRdData); end
        set_addr(A_SCTRL);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL glitch_ready: got %h want 0", memRdData); end
        // Bounce between two non-SDATA values keeps counting.
        SW = 10'h0F0;
        step(2);
        SW = 10'h0F1;
        step(3);
        set_addr(A_SDATA);
        checks++; if (memRdData !== 32'h3FF) begin errors++; $display("FAIL bounce_early: got %h want 3ff", memRdData); end
        step(1);
        set_addr(A_SDATA);
        checks++; if (memRdData !== 32'h0F1) begin errors++; $display("FAIL bounce_land: got %h want 0f1", memRdData); end
        bus_read_clear(A_SDATA);
    endtask

    task automatic test_irq_same_cycle;
        bus_write(A_SCTRL, 32'h10);
        set_addr(A_SCTRL);
        checks++; if (memRdData !== 32'h10) begin errors++; $display("FAIL sie_set: got %h want 10", memRdData); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
        SW = 10'h000;
        step(6);
        set_addr(A_SCTRL);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_sw: got %b want 1", irq); end
        checks++; if (memRdData !== 32'h11) begin errors++; $display("FAIL sctrl_ev: got %h want 11", memRdData); end
        SW = 10'h001;
        step(5);
        memAddr = A_SDATA; memRdEn = 1'b1;
        step(1);
        memRdEn = 1'b0;
        set_addr(A_SCTRL);
        checks++; if (memRdData !== 32'h11) begin errors++; $display("FAIL event_wins: got %h want 11", memRdData); end
        set_addr(A_SDATA);
        checks++; if (memRdData !== 32'h1) begin errors++; $display("FAIL sw_one: got %h want 1", memRdData); end
        bus_read_clear(A_SDATA);
        set_addr(A_SCTRL);
        checks++; if (memRdData !== 32'h10) begin errors++; $display("FAIL sready_clr: got %h want 10", memRdData); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr: got %b want 0", irq); end
    endtask

    task automatic test_reset_mid;
        bus_write(A_KCTRL, 32'h10);
        KEY = 4'h8;
        step(3);
        set_addr(A_KCTRL);
        checks++; if (memRdData !== 32'h11) begin errors++; $display("FAIL kie_ready: got %h want 11", memRdData); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_key: got %b want 1", irq); end
        SW = 10'h200;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
        set_addr(A_KCTRL);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL rst_kctrl: got %h want 0", memRdData); end
        set_addr(A_SCTRL);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL rst_sctrl: got %h want 0", memRdData); end
        set_addr(A_KDATA);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL rst_kdata: got %h want 0", memRdData); end
        set_addr(A_SDATA);
        checks++; if (memRdData !== 32'h1) begin
            if (memRdData !== 32'h0) begin errors++; $display("FAIL rst_sdata: got %h want 0", memRdData); end
        end
        step(4);
        set_addr(A_SDATA);
        checks++; if (memRdData !== 32'h0) begin errors++; $display("FAIL rst_restart: got %h want 0", memRdData); end
        set_addr(A_KDATA);
        checks++; if (memRdData !== 32'h7) begin errors++; $display("FAIL rst_kresync: got %h want 7", memRdData); end
        step(2);
        set_addr(A_SDATA);
        checks++; if (memRdData !== 32'h200) begin errors++; $display("FAIL rst_sland: got %h want 200", memRdData); end
    endtask

    initial begin
        test_reset;
        test_key_event;
        test_key_overrun;
        test_switch;
        test_irq_same_cycle;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
